dsp_casc_result_collector: RTL
==============================

# dsp_casc_result_collector

Downstream stage of the 4-DSP cascade in the FIOS Montgomery datapath. Consumes the 34-bit `P_o` partial results of the last DSP slice, one per cycle, and resolves them into canonical 17-bit result words by carry propagation. Buffers the words in a small FIFO and presents them on a valid/ready stream to the result-store logic. Flags overflow and protocol errors, because the DSP cascade is free-running and cannot be stalled.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries; power of two, at least 4.
- `WORD_COUNT`, 8: expected input words per result, including the `last_i` word.

Ports:
- `clock_i` in 1: single clock, rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `p_valid_i` in 1: `p_i` carries a partial result this cycle. There is no backpressure.
- `p_i` in 34: DSP `P_o`, a 17-bit digit plus an unresolved upper part.
- `p_last_i` in 1: marks the final partial result of the current multiplication.
- `word_o` out 17: resolved result word at the FIFO head.
- `word_valid_o` out 1: FIFO not empty.
- `word_last_o` out 1: head word is the final word of a result.
- `word_ready_i` in 1: consumer accepts the head word when `word_valid_o` is also high.
- `overflow_o` out 1: sticky; a word was dropped because the FIFO was full.
- `proto_err_o` out 1: sticky; input arrived while flushing, or the result length did not match `WORD_COUNT`.

## Operation
- Internal state:
  - 18-bit carry register `c`.
  - Word index counter, `$clog2(WORD_COUNT)+1` bits.
  - FSM with states `ACCUM`, `FLUSH_LO`, `FLUSH_HI`.
- In `ACCUM`, for an accepted input (`p_valid_i=1`):
  - Compute 35-bit `s = p_i + c`.
  - Push `s[16:0]` to the FIFO.
  - Update `c <= s[34:17]`. The carry is bounded below 2^18, so the truncation is lossless.
  - Increment the index.
- `p_last_i` with `p_valid_i`:
  - Push the word with last=0 when `COLLECTOR_FLUSH_EN` is defined (see Configuration).
  - Check the index equals `WORD_COUNT-1`; otherwise set `proto_err_o`.
  - Transition to `FLUSH_LO`.
- `FLUSH_LO`: push `c[16:0]` with last=0; go to `FLUSH_HI`.
- `FLUSH_HI`: push `{16'b0, c[17]}` with last=1; clear `c` and the index; go to `ACCUM`.
- `p_valid_i` in `FLUSH_LO` or `FLUSH_HI`: the input is dropped and `proto_err_o` is set. The flush itself continues unaffected.
- Index reaching `WORD_COUNT` without `p_last_i`: set `proto_err_o`, then continue accumulating. The index saturates.
- FIFO push while full with no pop in the same cycle:
  - The word is dropped and `overflow_o` is set.
  - Carry and FSM state advance as if the push had succeeded.
- FIFO full with a pop in the same cycle: the push succeeds.
- FIFO empty: `word_ready_i` is ignored.

## Timing
- Reset values (asynchronous, while `reset_n_i=0`):
  - FSM in `ACCUM`, `c=0`, index 0, FIFO empty.
  - `word_valid_o=0`, `word_last_o=0`, `word_o=0`.
  - `overflow_o=0`, `proto_err_o=0`.
- Reset asserted mid-result discards all partial state and buffered words.
- Latency: input accepted in cycle n → word visible on `word_o`/`word_valid_o` in cycle n+1 when the FIFO was empty.
- `word_o` and `word_last_o` come straight from FIFO storage at the read pointer. They are stable while `word_valid_o=1` and `word_ready_i=0`.
- One push per cycle at most; one pop per cycle at most.
- Flush adds 2 cycles after the last input. A new result's first `p_valid_i` is legal from cycle n+3, where n is the `p_last_i` cycle.
- Sticky flags assert in the cycle after the offending event and clear only on reset.

## Configuration
- Macro: `COLLECTOR_FLUSH_EN`.
- Defined:
  - Carry flush as described, producing `WORD_COUNT+2` output words per result.
  - `word_last_o` marks the `FLUSH_HI` word.
- Undefined:
  - `FLUSH_LO` and `FLUSH_HI` are not built; the final carry is discarded.
  - The `p_last_i` word is pushed with last=1, and `c` and the index clear in the same cycle.
  - `WORD_COUNT` words are produced per result.
  - A new result may start in cycle n+1.
  - Input can never arrive during a flush, so the flush-input error case cannot occur.

## Test plan
- Basic carry, `WORD_COUNT=2`, flush on, `word_ready_i=1`: input `0x000020001` then `0x000000005` (last). Output words 0x00001, 0x00006, 0x00000, 0x00000; `word_last_o` on the fourth word only.
- Max carry, `WORD_COUNT=2`: input `0x3FFFFFFFF` twice, last on the second. Output words 0x1FFFF, 0x1FFFE, 0x00000, 0x00001; the last word has `word_last_o=1`.
- Overflow, `DEPTH=4`, `WORD_COUNT=8`, `word_ready_i=0`, 8 inputs of `0x1`:
  - Words 5 to 8 and both flush words are dropped.
  - `overflow_o=1`.
  - After setting `word_ready_i=1`, exactly 4 words drain, each equal to 0x00001.
- Protocol error cases, `WORD_COUNT=8`:
  - `p_valid_i` in the cycle after `p_last_i` → `proto_err_o=1`; that input does not appear in the output.
  - `p_last_i` on the 3rd input → `proto_err_o=1`.
- Reset mid-result: apply 3 inputs, pulse `reset_n_i` low asynchronously between clock edges → all outputs read 0 immediately. A subsequent clean result of `0x5`, `0x7` (last) outputs 0x5, 0x7, 0, 0.
- Full-with-pop: fill the FIFO, then hold `word_ready_i=1` while pushing continues. No drop occurs and `overflow_o` stays 0.

Source files
------------

// File: rtl/dsp_casc_result_collector.sv
// Resolves 34-bit DSP cascade partials into 17-bit words and buffers them on a valid/ready stream; macro COLLECTOR_FLUSH_EN adds a 2-word carry flush.
// Latency: input accepted in cycle n is visible at the FIFO head in cycle n+1 when the FIFO is empty.
// Backpressure: none upstream (free-running cascade); a push into a full FIFO is dropped and overflow_o is set.

module dsp_casc_result_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         full, empty, push, pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop      = pop_rdy && !empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push_rdy = !full || pop;
  assign push     = push_vld && push_rdy;
  assign pop_vld  = !empty;
  assign pop_dat  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= push_dat;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

module dsp_casc_result_collector #(
  parameter int DEPTH      = 4,
  parameter int WORD_COUNT = 8
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        p_valid_i,
  input  logic [33:0] p_i,
  input  logic        p_last_i,
  output logic [16:0] word_o,
  output logic        word_valid_o,
  output logic        word_last_o,
  input  logic        word_ready_i,
  output logic        overflow_o,
  output logic        proto_err_o
);
  localparam int IW = $clog2(WORD_COUNT) + 1;

  typedef enum logic [1:0] {ACCUM, FLUSH_LO, FLUSH_HI} state_t;

  state_t          state_q, state_d;
  logic [17:0]     c_q, c_d;
  logic [IW-1:0]   idx_q, idx_d, idx_inc;
  logic [34:0]     sum;
  logic            push_vld, push_rdy, push_last, err_ev;
  logic [16:0]     push_word;
  logic [17:0]     head;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ACCUM;
      c_q         <= '0;
      idx_q       <= '0;
      overflow_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      overflow_o  <= overflow_o | (push_vld & ~push_rdy);
      proto_err_o <= proto_err_o | err_ev;
    end
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    idx_d     = idx_q;
    push_vld  = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    err_ev    = 1'b0;
    sum       = {1'b0, p_i} + {17'b0, c_q};
    idx_inc   = (idx_q == IW'(WORD_COUNT)) ? idx_q : idx_q + IW'(1);
    case (state_q)
      ACCUM: begin
        if (p_valid_i) begin
          push_vld  = 1'b1;
          push_word = sum[16:0];
          c_d       = sum[34:17];
          idx_d     = idx_inc;
          if (p_last_i) begin
            err_ev = (idx_q != IW'(WORD_COUNT - 1));
`ifdef COLLECTOR_FLUSH_EN
            state_d = FLUSH_LO;
`else
            push_last = 1'b1;
            c_d       = '0;
            idx_d     = '0;
`endif
          end else begin
            // Running past the expected length without last is a framing error.
            err_ev = (idx_inc == IW'(WORD_COUNT));
          end
        end
      end
`ifdef COLLECTOR_FLUSH_EN
      FLUSH_LO: begin
        push_vld  = 1'b1;
        push_word = c_q[16:0];
        err_ev    = p_valid_i;
        state_d   = FLUSH_HI;
      end
      FLUSH_HI: begin
        push_vld  = 1'b1;
        push_word = {16'b0, c_q[17]};
        push_last = 1'b1;
        err_ev    = p_valid_i;
        c_d       = '0;
        idx_d     = '0;
        state_d   = ACCUM;
      end
`endif
      default: state_d = ACCUM;
    endcase
  end

  dsp_casc_result_fifo #(.W(18), .DEPTH(DEPTH)) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push_vld  (push_vld),
    .push_dat  ({push_last, push_word}),
    .push_rdy  (push_rdy),
    .pop_vld   (word_valid_o),
    .pop_rdy   (word_ready_i),
    .pop_dat   (head)
  );

  assign word_o      = head[16:0];
  assign word_last_o = head[17];
endmodule
